// File: rtl/instr_fetch_decoder.sv
// Multi-cycle fetch/decode front end: imem req/ack read, IR latch, field split.
// Optional fetch watchdog enabled by defining FETCH_WATCHDOG_EN.
module instr_fetch_decoder #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_start,
   input  logic [31:0] pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [5:0]  opcode,
   output logic [3:0]  rd,
   output logic [3:0]  rs1,
   output logic [3:0]  rs2,
   output logic [31:0] ext_in,
   output logic        ext_op,
   output logic        busy,
   output logic        fetch_err
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] REQ    = 2'd1;
   localparam logic [1:0] DECODE = 2'd2;
   localparam logic [1:0] VALID  = 2'd3;

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic [31:0] ir;
   logic [31:0] imm;
   logic        imm_sx;
   logic        wd_abort;
   logic        take_pc;

`ifdef FETCH_WATCHDOG_EN
   logic [CNT_W-1:0] wd_cnt;

   // Ack in the same cycle as the limit wins over the abort.
   assign wd_abort = (state == REQ) && !imem_ack &&
                     (wd_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt    <= '0;
         fetch_err <= 1'b0;
      end else begin
         fetch_err <= wd_abort;
         if (state == REQ && !imem_ack && !wd_abort)
            wd_cnt <= wd_cnt + 1'b1;
         else
            wd_cnt <= '0;
      end
   end
`else
   assign wd_abort  = 1'b0;
   assign fetch_err = 1'b0;
`endif

   assign imem_req  = (state == REQ);
   assign dec_valid = (state == VALID);
   assign busy      = (state != IDLE);

   assign take_pc = fetch_start &&
                    ((state == IDLE) ||
                     (state == VALID && dec_ready));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (fetch_start) state_nxt = REQ;
         REQ: begin
            if (imem_ack)      state_nxt = DECODE;
            else if (wd_abort) state_nxt = IDLE;
         end
         DECODE:  state_nxt = VALID;
         VALID: begin
            if (dec_ready)
               state_nxt = fetch_start ? REQ : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      imm    = '0;
      imm_sx = 1'b0;
      unique case (ir[31:30])
         2'b00: begin
            imm    = '0;
            imm_sx = 1'b0;
         end
         2'b01: begin
            imm    = {16'b0, ir[17:2]};
            imm_sx = 1'b0;
         end
         2'b10: begin
            imm    = {16'b0, ir[17:2]};
            imm_sx = 1'b1;
         end
         2'b11: begin
            imm    = {6'b0, ir[25:0]};
            imm_sx = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         imem_addr <= '0;
         ir        <= '0;
         opcode    <= '0;
         rd        <= '0;
         rs1       <= '0;
         rs2       <= '0;
         ext_in    <= '0;
         ext_op    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (take_pc)
            imem_addr <= pc;
         if (state == REQ && imem_ack)
            ir <= imem_rdata;
         if (state == DECODE) begin
            opcode <= ir[31:26];
            rd     <= ir[25:22];
            rs1    <= ir[21:18];
            rs2    <= ir[17:14];
            ext_in <= imm;
            ext_op <= imm_sx;
         end
      end
   end

endmodule
